// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave that moves WIDTH-bit words between
// an external SPI master and the internal core using valid/ready handshakes.
// Supports all four SPI modes (CPOL/CPHA), MSB- or LSB-first bit order and
// back-to-back words within one chip-select frame. The sck, ss_n and mosi
// pins are asynchronous and pass through SYNC_STAGES-deep synchronisers.
// Optional macro SPI_RXBUF_EN: rx_valid is held until rx_ready accepts the
// word, and a word completing while rx_data is still unread is dropped and
// sets the sticky rx_overrun flag. Without the macro rx_valid is a one-cycle
// pulse, rx_ready is ignored and rx_overrun is tied low.
module spi_slave_param #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] FILL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             tx_underrun,
  output logic             rx_overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] r_sckSync;
  logic [SYNC_STAGES-1:0] r_ssSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sckPrev;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_bitCnt;
  logic [WIDTH-1:0]       r_txShift;
  logic [WIDTH-1:0]       r_rxShift;
  logic                   r_miso;
  logic                   r_misoOe;
  logic                   r_txReady;
  logic                   r_txUnderrun;
  logic                   r_busy;
  logic [WIDTH-1:0]       r_rxData;
  logic                   r_rxValid;

  logic                   w_sck;
  logic                   w_ss;
  logic                   w_mosi;
  logic                   w_sckEdge;
  logic                   w_lead;
  logic                   w_trail;
  logic                   w_sampleEdge;
  logic                   w_shiftEdge;
  logic [WIDTH-1:0]       w_loadWord;
  logic [WIDTH-1:0]       w_txShifted;
  logic [WIDTH-1:0]       w_rxNext;
  logic                   w_wordDone;

  // The bit that goes out first for a given word (MSB, or LSB when LSB_FIRST).
  function automatic logic firstBit(input logic [WIDTH-1:0] word);
    return (LSB_FIRST != 0) ? word[0] : word[WIDTH-1];
  endfunction

  assign w_sck  = r_sckSync[SYNC_STAGES-1];
  assign w_ss   = r_ssSync[SYNC_STAGES-1];
  assign w_mosi = r_mosiSync[SYNC_STAGES-1];

  assign w_sckEdge    = (w_sck != r_sckPrev);
  assign w_lead       = w_sckEdge && (w_sck != SCK_IDLE);
  assign w_trail      = w_sckEdge && (w_sck == SCK_IDLE);
  assign w_sampleEdge = (CPHA != 0) ? w_trail : w_lead;
  assign w_shiftEdge  = (CPHA != 0) ? w_lead : w_trail;

  assign w_loadWord  = tx_valid ? tx_data : FILL;
  assign w_txShifted = (LSB_FIRST != 0) ? {1'b0, r_txShift[WIDTH-1:1]}
                                        : {r_txShift[WIDTH-2:0], 1'b0};
  assign w_rxNext    = (LSB_FIRST != 0) ? {w_mosi, r_rxShift[WIDTH-1:1]}
                                        : {r_rxShift[WIDTH-2:0], w_mosi};

  // Completion does not look at ss_n, so a word whose last sample coincides
  // with the ss_n rise still reaches the core.
  assign w_wordDone = (r_state == ST_SHIFT) && w_sampleEdge && (r_bitCnt == LAST_BIT);

  // Bring the asynchronous pins into the clk domain, resetting to idle levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sckSync  <= {SYNC_STAGES{SCK_IDLE}};
      r_ssSync   <= {SYNC_STAGES{1'b1}};
      r_mosiSync <= {SYNC_STAGES{1'b1}};
      r_sckPrev  <= SCK_IDLE;
    end else begin
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], sck};
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], ss_n};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
      r_sckPrev  <= w_sck;
    end
  end

  // Frame FSM: load the tx word at frame start, then shift/sample on sck edges.
  // A shift edge while the bit counter is zero is skipped: for CPHA=0 that is
  // the trailing edge after a word's final sample, for CPHA=1 it is the first
  // leading edge of each word, which must keep bit 0 on miso.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bitCnt     <= '0;
      r_txShift    <= '0;
      r_rxShift    <= '0;
      r_miso       <= 1'b1;
      r_misoOe     <= 1'b0;
      r_txReady    <= 1'b0;
      r_txUnderrun <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_txReady    <= 1'b0;
      r_txUnderrun <= 1'b0;
      r_busy       <= ~w_ss;
      case (r_state)
        ST_IDLE: begin
          r_miso   <= 1'b1;
          r_misoOe <= 1'b0;
          r_bitCnt <= '0;
          if (!w_ss) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_ss) begin
            r_state  <= ST_IDLE;
            r_miso   <= 1'b1;
            r_misoOe <= 1'b0;
          end else begin
            r_txShift    <= w_loadWord;
            r_txReady    <= tx_valid;
            r_txUnderrun <= ~tx_valid;
            r_misoOe     <= 1'b1;
            r_miso       <= firstBit(w_loadWord);
            r_bitCnt     <= '0;
            r_state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_ss) begin
            r_state  <= ST_IDLE;
            r_miso   <= 1'b1;
            r_misoOe <= 1'b0;
            r_bitCnt <= '0;
          end else if (w_sampleEdge) begin
            r_rxShift <= w_rxNext;
            if (r_bitCnt == LAST_BIT) begin
              r_bitCnt     <= '0;
              r_txShift    <= w_loadWord;
              r_txReady    <= tx_valid;
              r_txUnderrun <= ~tx_valid;
              r_miso       <= firstBit(w_loadWord);
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end else if (w_shiftEdge && (r_bitCnt != '0)) begin
            r_txShift <= w_txShifted;
            r_miso    <= firstBit(w_txShifted);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPI_RXBUF_EN
  logic r_rxOverrun;
  logic w_pop;

  assign w_pop = r_rxValid && rx_ready;

  // rx_data doubles as the holding register; a word arriving while it is
  // still unread is dropped and flags a sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxData    <= '0;
      r_rxValid   <= 1'b0;
      r_rxOverrun <= 1'b0;
    end else if (w_wordDone) begin
      if (!r_rxValid || w_pop) begin
        r_rxData  <= w_rxNext;
        r_rxValid <= 1'b1;
      end else begin
        r_rxOverrun <= 1'b1;
      end
    end else if (w_pop) begin
      r_rxValid <= 1'b0;
    end
  end

  assign rx_overrun = r_rxOverrun;
`else
  logic w_unusedRxReady;

  assign w_unusedRxReady = rx_ready;

  // Present each completed word with a single-cycle rx_valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
    end else begin
      r_rxValid <= w_wordDone;
      if (w_wordDone) begin
        r_rxData <= w_rxNext;
      end
    end
  end

  assign rx_overrun = 1'b0;
`endif

  assign miso        = r_miso;
  assign miso_oe     = r_misoOe;
  assign tx_ready    = r_txReady;
  assign tx_underrun = r_txUnderrun;
  assign rx_data     = r_rxData;
  assign rx_valid    = r_rxValid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: drives two slaves (mode 0 MSB-first and mode 3
// LSB-first, WIDTH=8) from a behavioural SPI master and checks them against
// a word-level model: every reload takes the next offered tx word or FILL,
// every fully clocked mosi word is delivered once, in order, to the core.
module tb_spi_slave_param;

  localparam int HALF = 8;
`ifdef SPI_RXBUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sck, ssN, mosi, miso, misoOe;
  logic [1:0] txValid, txReady, rxValid, rxReady, txUnderrun, rxOverrun, busy;
  logic [7:0] txData [2];
  logic [7:0] rxData [2];

  logic [7:0] offerMem [2][256];
  int         drvHead [2];
  int         mdlHead [2];
  int         offerTail [2];
  logic [7:0] rxExp [2][256];
  int         rxHead [2];
  int         rxTail [2];
  int         txReadyCnt [2];
  int         underCnt [2];
  bit         holdReady;
  int         checks = 0;
  int         passes = 0;

  // System clock.
  always #5 clk = ~clk;

  spi_slave_param #(.WIDTH(8), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .sck(sck[0]), .ss_n(ssN[0]), .mosi(mosi[0]),
    .miso(miso[0]), .miso_oe(misoOe[0]), .tx_data(txData[0]), .tx_valid(txValid[0]),
    .tx_ready(txReady[0]), .rx_data(rxData[0]), .rx_valid(rxValid[0]),
    .rx_ready(rxReady[0]), .tx_underrun(txUnderrun[0]), .rx_overrun(rxOverrun[0]),
    .busy(busy[0]));

  spi_slave_param #(.WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) dut3 (
    .clk(clk), .rst(rst), .sck(sck[1]), .ss_n(ssN[1]), .mosi(mosi[1]),
    .miso(miso[1]), .miso_oe(misoOe[1]), .tx_data(txData[1]), .tx_valid(txValid[1]),
    .tx_ready(txReady[1]), .rx_data(rxData[1]), .rx_valid(rxValid[1]),
    .rx_ready(rxReady[1]), .tx_underrun(txUnderrun[1]), .rx_overrun(rxOverrun[1]),
    .busy(busy[1]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic offer(input int d, input logic [7:0] val);
    offerMem[d][offerTail[d] % 256] = val;
    offerTail[d]++;
  endtask

  task automatic expectRx(input int d, input logic [7:0] val);
    rxExp[d][rxTail[d] % 256] = val;
    rxTail[d]++;
  endtask

  // Model of one tx reload: next offered word if any is left, else FILL.
  task automatic modelReload(input int d, output logic [7:0] w, inout int pops, inout int fills);
    if (mdlHead[d] != offerTail[d]) begin
      w = offerMem[d][mdlHead[d] % 256];
      mdlHead[d]++;
      pops++;
    end else begin
      w = 8'hFF;
      fills++;
    end
  endtask

  // Core-side driver and compare process: counts pulses, advances the tx
  // offer on tx_ready, checks each delivered rx word and the idle pin levels.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        if (txReady[d]) begin
          txReadyCnt[d]++;
          drvHead[d]++;
        end
        if (txUnderrun[d]) underCnt[d]++;
        if (rxValid[d] && (rxReady[d] || !BUF)) begin
          if (rxHead[d] == rxTail[d]) begin
            checkOutput($sformatf("dut%0d spurious rx_valid", d), {31'd0, rxValid[d]}, 32'd0);
          end else begin
            checkOutput($sformatf("dut%0d rx_data", d), {24'd0, rxData[d]}, {24'd0, rxExp[d][rxHead[d] % 256]});
            rxHead[d]++;
          end
        end
        if (!busy[d]) begin
          checkOutput($sformatf("dut%0d idle miso_oe", d), {31'd0, misoOe[d]}, 32'd0);
          checkOutput($sformatf("dut%0d idle miso", d), {31'd0, miso[d]}, 32'd1);
        end
      end
      txValid[d] = (drvHead[d] != offerTail[d]);
      txData[d]  = offerMem[d][drvHead[d] % 256];
      rxReady[d] = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // SPI master: clocks nBits through dut d and returns what it read on miso.
  task automatic applyStimulus(input int d, input int nBits, input logic [7:0] mw [8],
                               output logic [7:0] rw [8]);
    bit cpol = (d == 1);
    bit cpha = (d == 1);
    bit lsb  = (d == 1);
    int k, p;
    for (int i = 0; i < 8; i++) rw[i] = 8'h00;
    ssN[d] = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < nBits; i++) begin
      k = i / 8;
      p = lsb ? (i % 8) : (7 - i % 8);
      if (!cpha) begin
        mosi[d] = mw[k][p];
        repeat (HALF) @(negedge clk);
        sck[d] = ~cpol;
        rw[k][p] = miso[d];
        repeat (HALF) @(negedge clk);
        sck[d] = cpol;
      end else begin
        sck[d] = ~cpol;
        mosi[d] = mw[k][p];
        repeat (HALF) @(negedge clk);
        sck[d] = cpol;
        rw[k][p] = miso[d];
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
    ssN[d] = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // One frame of nWords full words plus an optional partial word, checked
  // against the word-level model.
  task automatic runFrame(input int d, input int nWords, input int partial,
                          input logic [7:0] mw [8], input bit expectDrain,
                          output logic [7:0] rw [8]);
    logic [7:0] expTx [8];
    logic [7:0] mask;
    int pops = 0;
    int fills = 0;
    int rdy0 = txReadyCnt[d];
    int und0 = underCnt[d];
    for (int k = 0; k <= nWords; k++) modelReload(d, expTx[k], pops, fills);
    for (int k = 0; k < nWords; k++) expectRx(d, mw[k]);
    applyStimulus(d, nWords * 8 + partial, mw, rw);
    for (int k = 0; k < nWords; k++)
      checkOutput($sformatf("dut%0d master word %0d", d, k), {24'd0, rw[k]}, {24'd0, expTx[k]});
    if (partial > 0) begin
      mask = (d == 1) ? (8'hFF >> (8 - partial)) : (8'hFF << (8 - partial));
      checkOutput($sformatf("dut%0d partial word", d), {24'd0, rw[nWords] & mask},
                  {24'd0, expTx[nWords] & mask});
    end
    checkOutput($sformatf("dut%0d tx_ready count", d), txReadyCnt[d] - rdy0, pops);
    checkOutput($sformatf("dut%0d tx_underrun count", d), underCnt[d] - und0, fills);
    checkOutput($sformatf("dut%0d busy after frame", d), {31'd0, busy[d]}, 32'd0);
    if (expectDrain) checkOutput($sformatf("dut%0d rx drained", d), rxHead[d], rxTail[d]);
  endtask

  task automatic checkReset(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s dut%0d miso", tag, d), {31'd0, miso[d]}, 32'd1);
      checkOutput($sformatf("%s dut%0d miso_oe", tag, d), {31'd0, misoOe[d]}, 32'd0);
      checkOutput($sformatf("%s dut%0d rx_valid", tag, d), {31'd0, rxValid[d]}, 32'd0);
      checkOutput($sformatf("%s dut%0d rx_data", tag, d), {24'd0, rxData[d]}, 32'd0);
      checkOutput($sformatf("%s dut%0d busy", tag, d), {31'd0, busy[d]}, 32'd0);
      checkOutput($sformatf("%s dut%0d tx_ready", tag, d), {31'd0, txReady[d]}, 32'd0);
      checkOutput($sformatf("%s dut%0d tx_underrun", tag, d), {31'd0, txUnderrun[d]}, 32'd0);
      checkOutput($sformatf("%s dut%0d rx_overrun", tag, d), {31'd0, rxOverrun[d]}, 32'd0);
    end
  endtask

  // Directed scenarios, then randomized frames on both slaves.
  initial begin
    logic [7:0] mw [8];
    logic [7:0] rw [8];
    int base, nW, part, nOff;
    rst = 1'b1;
    sck = 2'b10;
    ssN = 2'b11;
    mosi = 2'b11;
    holdReady = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drvHead[d] = 0; mdlHead[d] = 0; offerTail[d] = 0;
      rxHead[d] = 0; rxTail[d] = 0; txReadyCnt[d] = 0; underCnt[d] = 0;
    end
    for (int i = 0; i < 8; i++) mw[i] = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkReset("reset");

    $display("[TB] mode 0 single byte");
    base = txReadyCnt[0];
    offer(0, 8'hA5);
    mw[0] = 8'h3C;
    runFrame(0, 1, 0, mw, 1'b1, rw);
    checkOutput("mode0 master reads A5", {24'd0, rw[0]}, 32'hA5);
    checkOutput("mode0 rx_data 3C", {24'd0, rxData[0]}, 32'h3C);
    checkOutput("mode0 one tx_ready", txReadyCnt[0] - base, 1);

    $display("[TB] mode 3 LSB-first byte");
    offer(1, 8'h81);
    mw[0] = 8'h7E;
    runFrame(1, 1, 0, mw, 1'b1, rw);
    checkOutput("mode3 master reads 81", {24'd0, rw[0]}, 32'h81);
    checkOutput("mode3 rx_data 7E", {24'd0, rxData[1]}, 32'h7E);

    $display("[TB] three back-to-back words");
    base = txReadyCnt[0];
    part = rxHead[0];
    offer(0, 8'hA1); offer(0, 8'hB2); offer(0, 8'hC3);
    mw[0] = 8'h11; mw[1] = 8'h22; mw[2] = 8'h33;
    runFrame(0, 3, 0, mw, 1'b1, rw);
    checkOutput("b2b master word 2", {24'd0, rw[2]}, 32'hC3);
    checkOutput("b2b three tx_ready", txReadyCnt[0] - base, 3);
    checkOutput("b2b three rx words", rxHead[0] - part, 3);

    $display("[TB] underrun at frame start");
    base = underCnt[0];
    mw[0] = 8'h00;
    runFrame(0, 1, 0, mw, 1'b1, rw);
    checkOutput("underrun master reads FF", {24'd0, rw[0]}, 32'hFF);
    checkOutput("underrun pulses", underCnt[0] - base, 2);

    $display("[TB] frame aborted after 5 bits");
    part = rxHead[0];
    offer(0, 8'h96);
    mw[0] = 8'hE7;
    runFrame(0, 0, 5, mw, 1'b1, rw);
    checkOutput("abort no rx word", rxHead[0] - part, 0);
    checkOutput("abort miso_oe", {31'd0, misoOe[0]}, 32'd0);
    checkOutput("abort miso", {31'd0, miso[0]}, 32'd1);
    offer(0, 8'hC3);
    mw[0] = 8'h5A;
    runFrame(0, 1, 0, mw, 1'b1, rw);
    checkOutput("after abort rx_data 5A", {24'd0, rxData[0]}, 32'h5A);
    checkOutput("after abort master reads C3", {24'd0, rw[0]}, 32'hC3);

`ifdef SPI_RXBUF_EN
    $display("[TB] receive overrun with rx_ready low");
    holdReady = 1'b1;
    repeat (2) @(negedge clk);
    mw[0] = 8'hAA; mw[1] = 8'h55;
    runFrame(0, 2, 0, mw, 1'b0, rw);
    checkOutput("overrun rx_data held AA", {24'd0, rxData[0]}, 32'hAA);
    checkOutput("overrun rx_valid held", {31'd0, rxValid[0]}, 32'd1);
    checkOutput("overrun flag set", {31'd0, rxOverrun[0]}, 32'd1);
    rxTail[0]--;
    holdReady = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("overrun held word delivered", rxHead[0], rxTail[0]);
    checkOutput("overrun flag sticky", {31'd0, rxOverrun[0]}, 32'd1);
`else
    checkOutput("no overrun without buffer", {31'd0, rxOverrun[0]}, 32'd0);
`endif

    $display("[TB] randomized frames");
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 12; f++) begin
        nW = $urandom_range(1, 3);
        part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
        nOff = $urandom_range(0, nW + 1);
        for (int i = 0; i < nOff; i++) offer(d, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 8; i++) mw[i] = 8'($urandom_range(0, 255));
        runFrame(d, nW, part, mw, 1'b1, rw);
      end
    end

    $display("[TB] reset in the middle of a frame");
    ssN[0] = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("selected miso_oe", {31'd0, misoOe[0]}, 32'd1);
    checkOutput("selected busy", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    ssN[0] = 1'b1;
    repeat (2) @(negedge clk);
    checkReset("midframe reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
